alu16_seq_arb: RTL and testbench

Shared-ALU controller. Two requesters compete for one 4-bit ALU slice. Each WIDTH-bit operation is executed serially, one nibble per cycle, least significant nibble first, with the carry held in a register between nibbles. The block sits between the issuing logic and the arithmetic datapath. It arbitrates round-robin and returns each result with a valid/ready response handshake.

---
 rtl/alu_seq_pkg.sv | 24 ++
 rtl/alu_nibble.sv | 49 ++++
 rtl/alu16_seq_arb.sv | 188 ++++++++++++++++++
 tb/tb_alu16_seq_arb.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_pkg
// Brief    : Shared definitions for the nibble-serial shared-ALU controller:
//            op codes, slice width and controller FSM encoding.
// Revision : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

  localparam int NIBBLE_W = 4;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/alu_nibble.sv
`default_nettype none
// ============================================================================
// Module   : alu_nibble
// Brief    : Combinational 4-bit ALU slice (AND / OR / ADD). Op 11 yields
//            zero; subtraction is built by the controller as ADD with ~b.
// Revision : 1.0 - initial release
// ============================================================================
module alu_nibble
  import alu_seq_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  input  logic [1:0]          op,
  output logic [NIBBLE_W-1:0] res,
  output logic                cout
);

  logic [NIBBLE_W:0]   carry;
  logic [NIBBLE_W-1:0] sum;

  // Ripple full-adder chain, then select the result by op code.
  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = cin;
    for (int i = 0; i < NIBBLE_W; i++) begin
      sum[i]     = a[i] ^ b[i] ^ carry[i];
      carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    res  = '0;
    cout = 1'b0;
    case (op)
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_ADD: begin
        res  = sum;
        cout = carry[NIBBLE_W];
      end
      default: begin
        res  = '0;
        cout = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu16_seq_arb.sv
`default_nettype none
// ============================================================================
// Module   : alu16_seq_arb
// Brief    : Two-requester round-robin controller for one 4-bit ALU slice.
//            Each WIDTH-bit operation runs LS nibble first, one nibble per
//            cycle, carry held in a register; result returned over a
//            valid/ready response handshake.
// Config   : ALU_SEQ_SUB_EN - when defined, op 11 computes a - b as
//            a + ~b + 1 (cin ignored); otherwise op 11 returns zero.
// Revision : 1.0 - initial release
// ============================================================================
module alu16_seq_arb
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [1:0]       req0_op,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [1:0]       req1_op,
  input  logic             req1_cin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_res,
  output logic             rsp_cout,
  output logic             rsp_id
);

  localparam int NIB   = WIDTH / NIBBLE_W;
  localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIB - 1);

  state_e               state_q, state_d;
  logic                 last_grant_q, last_grant_d;
  logic [CNT_W-1:0]     nib_cnt_q, nib_cnt_d;
  logic                 carry_q, carry_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [1:0]           op_q, op_d;
  logic [WIDTH-1:0]     res_q, res_d;
  logic                 cout_q, cout_d;
  logic                 id_q, id_d;
  logic                 valid_q, valid_d;

  logic                 grant0, grant1;
  logic                 sel1;
  logic [1:0]           sel_op;
  logic [NIBBLE_W-1:0]  slice_a, slice_b, slice_res;
  logic [1:0]           slice_op;
  logic                 slice_cout;
  int                   lsb;

  // Round-robin grant: a lone requester wins; on a tie the one not granted
  // last wins. Ready is held low while reset is asserted.
  always_comb begin
    grant0     = req0_valid && (!req1_valid || last_grant_q);
    grant1     = req1_valid && (!req0_valid || !last_grant_q);
    req0_ready = rst_n && (state_q == IDLE) && grant0;
    req1_ready = rst_n && (state_q == IDLE) && grant1;
    sel1       = req1_ready;
    sel_op     = sel1 ? req1_op : req0_op;
  end

  // Present the current nibble of the latched operands to the slice.
  always_comb begin
    lsb      = int'(nib_cnt_q) * NIBBLE_W;
    slice_a  = a_q[lsb +: NIBBLE_W];
    slice_b  = b_q[lsb +: NIBBLE_W];
    slice_op = op_q;
`ifdef ALU_SEQ_SUB_EN
    if (op_q == OP_SUB) begin
      slice_b  = ~b_q[lsb +: NIBBLE_W];
      slice_op = OP_ADD;
    end
`endif
  end

  alu_nibble u_alu_nibble (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .op   (slice_op),
    .res  (slice_res),
    .cout (slice_cout)
  );

  // Next-state and datapath update for the accept / execute / respond cycle.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    nib_cnt_d    = nib_cnt_q;
    carry_d      = carry_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    res_d        = res_q;
    cout_d       = cout_q;
    id_d         = id_q;
    valid_d      = valid_q;

    case (state_q)
      IDLE: begin
        if (req0_ready || req1_ready) begin
          state_d      = EXEC;
          last_grant_d = sel1;
          id_d         = sel1;
          a_d          = sel1 ? req1_a   : req0_a;
          b_d          = sel1 ? req1_b   : req0_b;
          op_d         = sel_op;
          carry_d      = sel1 ? req1_cin : req0_cin;
`ifdef ALU_SEQ_SUB_EN
          if (sel_op == OP_SUB) begin
            carry_d = 1'b1;
          end
`endif
          nib_cnt_d    = '0;
        end
      end
      EXEC: begin
        res_d[lsb +: NIBBLE_W] = slice_res;
        carry_d                = slice_cout;
        if (nib_cnt_q == LAST_NIB) begin
          nib_cnt_d = '0;
          cout_d    = slice_cout;
          valid_d   = 1'b1;
          state_d   = DONE;
        end else begin
          nib_cnt_d = nib_cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      nib_cnt_q    <= '0;
      carry_q      <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= OP_AND;
      res_q        <= '0;
      cout_q       <= 1'b0;
      id_q         <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      nib_cnt_q    <= nib_cnt_d;
      carry_q      <= carry_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      res_q        <= res_d;
      cout_q       <= cout_d;
      id_q         <= id_d;
      valid_q      <= valid_d;
    end
  end

  assign rsp_valid = valid_q;
  assign rsp_res   = res_q;
  assign rsp_cout  = cout_q;
  assign rsp_id    = id_q;

endmodule
`default_nettype wire

// File: tb/tb_alu16_seq_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu16_seq_arb
// Brief    : Self-checking bench for alu16_seq_arb: directed cases plus
//            randomized transactions against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu16_seq_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0]  req0_op, req1_op;
  logic        req0_cin, req1_cin;
  logic        rsp_valid, rsp_ready, rsp_cout, rsp_id;
  logic [15:0] rsp_res;

  int n_checks = 0;
  int n_errors = 0;
  bit m_last   = 1'b1;

  always #5 clk = ~clk;

  alu16_seq_arb #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req0_cin   (req0_cin),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .req1_cin   (req1_cin),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_res    (rsp_res),
    .rsp_cout   (rsp_cout),
    .rsp_id     (rsp_id)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: {cout, result} straight from the arithmetic definition.
  function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic [1:0] op, input logic cin);
    logic [16:0] r;
    case (op)
      2'b00:   r = {1'b0, a & b};
      2'b01:   r = {1'b0, a | b};
      2'b10:   r = 17'(a) + 17'(b) + 17'(cin);
`ifdef ALU_SEQ_SUB_EN
      default: r = 17'(a) + 17'(~b) + 17'd1;
`else
      default: r = 17'd0;
`endif
    endcase
    return r;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_valid"}, 32'(rsp_valid), 32'd0);
    check_val({tag, "_res"},   32'(rsp_res),   32'd0);
    check_val({tag, "_cout"},  32'(rsp_cout),  32'd0);
    check_val({tag, "_id"},    32'(rsp_id),    32'd0);
    check_val({tag, "_rdy0"},  32'(req0_ready), 32'd0);
    check_val({tag, "_rdy1"},  32'(req1_ready), 32'd0);
  endtask

  // One complete transaction; called at a negedge with the DUT idle.
  task automatic run_txn(input bit v0, input bit v1,
                         input logic [15:0] a0, input logic [15:0] b0,
                         input logic [1:0] op0, input logic cin0,
                         input logic [15:0] a1, input logic [15:0] b1,
                         input logic [1:0] op1, input logic cin1,
                         input int hold);
    bit          g;
    logic [16:0] exp;
    int          cnt;
    g = (v0 && v1) ? ~m_last : v1;
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0; req0_cin = cin0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1; req1_cin = cin1;
    #1;
    check_val("grant0", 32'(req0_ready), 32'(g == 1'b0));
    check_val("grant1", 32'(req1_ready), 32'(g == 1'b1));
    m_last = g;
    exp = g ? model(a1, b1, op1, cin1) : model(a0, b0, op0, cin0);
    @(posedge clk);
    @(negedge clk);
    if (g) req1_valid = 1'b0; else req0_valid = 1'b0;
    cnt = 0;
    while (!rsp_valid && cnt < 20) begin
      if (req0_valid || req1_valid) begin
        check_val("busy_rdy", 32'({req0_ready, req1_ready}), 32'd0);
      end
      @(negedge clk);
      cnt++;
    end
    check_val("latency", 32'(cnt), 32'd4);
    check_val("res",  32'(rsp_res),  32'(exp[15:0]));
    check_val("cout", 32'(rsp_cout), 32'(exp[16]));
    check_val("id",   32'(rsp_id),   32'(g));
    repeat (hold) begin
      @(negedge clk);
      check_val("hold_valid", 32'(rsp_valid), 32'd1);
      check_val("hold_res",   32'(rsp_res),   32'(exp[15:0]));
      check_val("hold_cout",  32'(rsp_cout),  32'(exp[16]));
      check_val("hold_id",    32'(rsp_id),    32'(g));
      check_val("hold_rdy",   32'({req0_ready, req1_ready}), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready  = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check_val("post_hs_valid", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b0;
    req0_a = '0; req0_b = '0; req0_op = 2'b00; req0_cin = 1'b0;
    req1_a = '0; req1_b = '0; req1_op = 2'b00; req1_cin = 1'b0;
    #1;
    check_idle_outputs("rst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Tie from reset release: grants alternate 0, 1, 0.
    run_txn(1, 1, 16'h1111, 16'h0101, 2'b10, 0, 16'h2222, 16'h0202, 2'b10, 0, 0);
    run_txn(1, 1, 16'h1111, 16'h0101, 2'b10, 1, 16'h2222, 16'h0202, 2'b10, 1, 0);
    run_txn(1, 1, 16'hAAAA, 16'h5555, 2'b01, 0, 16'h2222, 16'h0202, 2'b10, 0, 0);

    // Directed arithmetic cases.
    run_txn(1, 0, 16'hFFFF, 16'h0001, 2'b10, 0, 16'h0, 16'h0, 2'b00, 0, 0);
    run_txn(1, 0, 16'hF0F0, 16'h3C3C, 2'b00, 1, 16'h0, 16'h0, 2'b00, 0, 0);
    run_txn(0, 1, 16'h0, 16'h0, 2'b00, 0, 16'hF0F0, 16'h3C3C, 2'b01, 1, 0);
    run_txn(1, 0, 16'h0005, 16'h0003, 2'b11, 0, 16'h0, 16'h0, 2'b00, 0, 10);
    run_txn(0, 1, 16'h0, 16'h0, 2'b00, 0, 16'h0003, 16'h0005, 2'b11, 0, 2);

    // Reset during the second nibble: outputs clear, no response appears.
    req0_valid = 1'b1; req0_a = 16'h7777; req0_b = 16'h1111; req0_op = 2'b10; req0_cin = 1'b0;
    #1;
    check_val("mid_rdy0", 32'(req0_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    req0_valid = 1'b1;
    #1;
    check_idle_outputs("mid_rst");
    m_last = 1'b1;
    @(negedge clk);
    req0_valid = 1'b0;
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check_val("no_rsp", 32'(rsp_valid), 32'd0);
    end
    run_txn(0, 1, 16'h0, 16'h0, 2'b00, 0, 16'h1234, 16'h1111, 2'b10, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      int m;
      m = int'($urandom_range(1, 3));
      run_txn(m[0], m[1],
              16'($urandom), 16'($urandom), 2'($urandom), 1'($urandom),
              16'($urandom), 16'($urandom), 2'($urandom), 1'($urandom),
              int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
